// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } recv_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int unsigned ERR_PAR = 0;
  localparam int unsigned ERR_FRM = 1;
  localparam int unsigned ERR_BRK = 2;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req < 4'd5)
      return 4'd5;
    else if (req > max_bits)
      return max_bits;
    else
      return req;
  endfunction

  // xor_data is the running XOR of the received data bits
  function automatic logic parity_error(input logic [1:0] mode, input logic xor_data,
                                        input logic par_bit);
    unique case (mode)
      PAR_EVEN: return xor_data ^ par_bit;
      PAR_ODD:  return ~(xor_data ^ par_bit);
      PAR_MARK: return ~par_bit;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads zero while empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_recv_fifo.sv
// Oversampling UART receiver with runtime framing config, break detection
// and an RX FIFO carrying per-word {break, framing, parity} flags.
module uart_recv_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         active,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [3:0]                   cfg_data_bits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_stop,
  input  logic                         rx,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_W-1:0]            rd_data,
  output logic [2:0]                   rd_err,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy,
  output logic                         recv,
  output logic                         overrun,
  input  logic                         ovr_clr
);

  localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] IDX_A   = SAMP_W'(OVERSAMPLE/2 - 1);
  localparam logic [SAMP_W-1:0] IDX_B   = SAMP_W'(OVERSAMPLE/2);
  localparam logic [SAMP_W-1:0] IDX_MID = SAMP_W'(OVERSAMPLE/2 + 1);
  localparam logic [SAMP_W-1:0] IDX_END = SAMP_W'(OVERSAMPLE - 1);

  recv_state_e state, state_next;

  logic rx_s1, rx_s2, rx_d;
  logic fall, start_edge;
  logic [DIV_W-1:0]  tick_cnt, div_q;
  logic [SAMP_W-1:0] samp_idx;
  logic tick, mid, bit_end;
  logic s0, s1, bit_val;
  logic rx_hi;

  logic [DATA_W-1:0] data_q;
  logic [3:0]        bit_cnt, nbits_q;
  logic [1:0]        par_q;
  logic              stop2_q, xor_q, zero_q, par_err_q, stop1_bad_q;

  logic       done;
  logic [2:0] err_now;
  logic       push_q;
  logic [DATA_W+2:0] push_word;
  logic [DATA_W+2:0] head;
  logic       full, empty, pop;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall       = rx_d & ~rx_s2;
  assign start_edge = (state == IDLE) & active & fall;
  assign tick       = (tick_cnt == '0);
  assign mid        = tick & (samp_idx == IDX_MID);
  assign bit_end    = tick & (samp_idx == IDX_END);
  assign bit_val    = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tick_cnt <= '0;
      samp_idx <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
    end else if (start_edge) begin
      tick_cnt <= cfg_div;
      samp_idx <= '0;
    end else if (tick) begin
      tick_cnt <= div_q;
      samp_idx <= (samp_idx == IDX_END) ? '0 : samp_idx + 1'b1;
      if (samp_idx == IDX_A)
        s0 <= rx_s2;
      if (samp_idx == IDX_B)
        s1 <= rx_s2;
    end else begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  // Break recovery needs the line high across a whole tick interval
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      rx_hi <= 1'b0;
    else if (state != BRK_WAIT || !rx_s2)
      rx_hi <= 1'b0;
    else if (tick)
      rx_hi <= 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    err_now    = '0;
    unique case (state)
      IDLE: if (fall) state_next = START;
      START: begin
        if (mid && bit_val)
          state_next = IDLE;
        else if (bit_end)
          state_next = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == nbits_q - 4'd1)
          state_next = (par_q == PAR_NONE) ? STOP1 : PARITY;
      end
      PARITY: if (bit_end) state_next = STOP1;
      STOP1: begin
        if (stop2_q) begin
          if (bit_end)
            state_next = STOP2;
        end else if (mid) begin
          done             = 1'b1;
          err_now[ERR_PAR] = par_err_q;
          err_now[ERR_FRM] = ~bit_val;
          err_now[ERR_BRK] = zero_q & ~bit_val;
          state_next       = err_now[ERR_BRK] ? BRK_WAIT : IDLE;
        end
      end
      STOP2: begin
        if (mid) begin
          done             = 1'b1;
          err_now[ERR_PAR] = par_err_q;
          err_now[ERR_FRM] = stop1_bad_q | ~bit_val;
          err_now[ERR_BRK] = zero_q & stop1_bad_q;
          state_next       = err_now[ERR_BRK] ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: if (tick && rx_hi && rx_s2) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!active) begin
      state_next = IDLE;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      div_q       <= '0;
      nbits_q     <= 4'd5;
      par_q       <= PAR_NONE;
      stop2_q     <= 1'b0;
      data_q      <= '0;
      bit_cnt     <= '0;
      xor_q       <= 1'b0;
      zero_q      <= 1'b1;
      par_err_q   <= 1'b0;
      stop1_bad_q <= 1'b0;
    end else if (start_edge) begin
      div_q       <= cfg_div;
      nbits_q     <= clamp_bits(cfg_data_bits, 4'(DATA_W));
      par_q       <= cfg_parity;
      stop2_q     <= cfg_stop;
      data_q      <= '0;
      bit_cnt     <= '0;
      xor_q       <= 1'b0;
      zero_q      <= 1'b1;
      par_err_q   <= 1'b0;
      stop1_bad_q <= 1'b0;
    end else if (mid) begin
      unique case (state)
        DATA: begin
          for (int unsigned i = 0; i < DATA_W; i++)
            if (i == 32'(bit_cnt))
              data_q[i] <= bit_val;
          xor_q  <= xor_q ^ bit_val;
          zero_q <= zero_q & ~bit_val;
        end
        PARITY: begin
          par_err_q <= parity_error(par_q, xor_q, bit_val);
          zero_q    <= zero_q & ~bit_val;
        end
        STOP1:   stop1_bad_q <= ~bit_val;
        default: ;
      endcase
    end else if (bit_end && state == DATA) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      push_q    <= 1'b0;
      push_word <= '0;
      overrun   <= 1'b0;
    end else begin
      push_q <= done;
      if (done)
        push_word <= {err_now, data_q};
      if (push_q && full && !pop)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  assign pop      = rd_valid & rd_ready;
  assign rd_valid = ~empty;
  assign rd_data  = head[DATA_W-1:0];
  assign rd_err   = head[DATA_W+2:DATA_W];
  assign busy     = (state != IDLE);
  assign recv     = push_q;

  uart_sync_fifo #(
    .WIDTH (DATA_W + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst      (arst),
    .push      (push_q),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_recv_fifo.sv
// Scoreboard bench for uart_recv_fifo: directed frames, queue of expected words.
module tb_uart_recv_fifo;

  localparam int DATA_W   = 9;
  localparam int DEPTH    = 4;
  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        arst;
  logic        active;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop;
  logic        rx;
  logic        rd_valid;
  logic        rd_ready;
  logic [8:0]  rd_data;
  logic [2:0]  rd_err;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        recv;
  logic        overrun;
  logic        ovr_clr;

  int checks = 0;
  int fails  = 0;
  int recv_cnt;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  uart_recv_fifo #(
    .DATA_W     (DATA_W),
    .OVERSAMPLE (16),
    .DIV_W      (16),
    .DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .active        (active),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop      (cfg_stop),
    .rx            (rx),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .recv          (recv),
    .overrun       (overrun),
    .ovr_clr       (ovr_clr)
  );

  always @(posedge clk or posedge arst)
    if (arst) recv_cnt <= 0;
    else if (recv) recv_cnt <= recv_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t",
                   {rd_err, rd_data}, $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_word", 32'({rd_err, rd_data}), 32'(e));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input logic [1:0] par,
                            input logic par_flip, input logic two_stop,
                            input logic stop1, input logic stop2);
    logic x;
    x = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(data[i]);
      x ^= data[i];
    end
    if (par == 2'b01)      send_bit(x ^ par_flip);
    else if (par == 2'b10) send_bit(~x ^ par_flip);
    else if (par == 2'b11) send_bit(1'b1 ^ par_flip);
    send_bit(stop1);
    if (two_stop) send_bit(stop2);
    rx = 1'b1;
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic st);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop      = st;
  endtask

  initial begin
    int r0;
    arst = 1'b1; active = 1'b1; cfg_div = 16'd3; rx = 1'b1;
    rd_ready = 1'b0; ovr_clr = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0);
    idle(4);
    check("reset_rd_valid", 32'(rd_valid), 0);
    check("reset_count", 32'(fifo_count), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_rd_data", 32'({rd_err, rd_data}), 0);
    arst = 1'b0;
    idle(4);
    check("post_reset_recv", 32'(recv), 0);
    fork monitor(); join_none

    // 8N1 0xA5, held in FIFO before popping
    exp_q.push_back({3'b000, 9'h0A5});
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(BIT_CLKS);
    check("a5_rd_valid", 32'(rd_valid), 1);
    check("a5_rd_data", 32'(rd_data), 32'h0A5);
    check("a5_rd_err", 32'(rd_err), 0);
    check("a5_count", 32'(fifo_count), 1);
    check("a5_recv_cnt", 32'(recv_cnt), 1);
    rd_ready = 1'b1;
    idle(4);
    check("a5_popped", 32'(fifo_count), 0);

    // 7E2 with bad parity, then bad parity plus bad second stop
    set_cfg(4'd7, 2'b01, 1'b1);
    exp_q.push_back({3'b001, 9'h035});
    send_frame(9'h035, 7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(BIT_CLKS);
    exp_q.push_back({3'b011, 9'h035});
    send_frame(9'h035, 7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(BIT_CLKS);
    check("7e2_recv_cnt", 32'(recv_cnt), 3);

    // False start
    set_cfg(4'd8, 2'b00, 1'b0);
    r0 = recv_cnt;
    rx = 1'b0;
    idle(10);
    check("fs_busy_high", 32'(busy), 1);
    idle(10);
    rx = 1'b1;
    idle(60);
    check("fs_busy_low", 32'(busy), 0);
    check("fs_count", 32'(fifo_count), 0);
    check("fs_no_recv", 32'(recv_cnt), 32'(r0));

    // Overrun: five frames into a four-deep FIFO
    rd_ready = 1'b0;
    r0 = recv_cnt;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back({3'b000, 9'(v)});
      send_frame(9'(v), 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle(BIT_CLKS);
    check("ovr_count", 32'(fifo_count), 4);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_recv_cnt", 32'(recv_cnt), 32'(r0 + 5));
    rd_ready = 1'b1;
    idle(8);
    check("ovr_drained", 32'(fifo_count), 0);
    check("ovr_sticky", 32'(overrun), 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    idle(1);
    check("ovr_cleared", 32'(overrun), 0);

    // Break: 12 bit-times low
    r0 = recv_cnt;
    exp_q.push_back({3'b110, 9'h000});
    rx = 1'b0;
    idle(11 * BIT_CLKS);
    check("brk_busy", 32'(busy), 1);
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(3);
    check("brk_busy_hold", 32'(busy), 1);
    idle(20);
    check("brk_busy_low", 32'(busy), 0);
    idle(2 * BIT_CLKS);
    check("brk_one_entry", 32'(recv_cnt), 32'(r0 + 1));

    // Drop active mid-DATA, then a clean frame
    r0 = recv_cnt;
    fork
      send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        idle(3 * BIT_CLKS + 10);
        check("drop_busy_before", 32'(busy), 1);
        active = 1'b0;
        idle(1);
        check("drop_busy_after", 32'(busy), 0);
      end
    join
    idle(BIT_CLKS);
    check("drop_no_recv", 32'(recv_cnt), 32'(r0));
    active = 1'b1;
    idle(BIT_CLKS);
    exp_q.push_back({3'b000, 9'h03C});
    send_frame(9'h03C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(BIT_CLKS);
    check("drop_recv_cnt", 32'(recv_cnt), 32'(r0 + 1));
    check("final_count", 32'(fifo_count), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
